// File: rtl/axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_master
// Brief    : AXI4 read master. Accepts one burst command at a time from the
//            read buffer, issues a single INCR AR transaction, forwards each
//            R beat (registered) back to the buffer and flags response,
//            length, 4 KB boundary and R-channel stall errors.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_master #(
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int TIMEOUT_CYC    = 1024
) (
   input  logic                      clk,
   input  logic                      reset_n,
   // command side (read buffer)
   input  logic                      rd_req_en,
   output logic                      rd_req_ack,
   input  logic [AXI_ADDR_WIDTH-1:0] rd_addr,
   input  logic [7:0]                rd_burst_len,
   // data side (read buffer)
   output logic                      rd_data_valid,
   output logic [AXI_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_data_last,
   // AXI AR channel
   output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]                m_axi_arlen,
   output logic [2:0]                m_axi_arsize,
   output logic [1:0]                m_axi_arburst,
   output logic                      m_axi_arlock,
   output logic [3:0]                m_axi_arcache,
   output logic [2:0]                m_axi_arprot,
   output logic [3:0]                m_axi_arqos,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   // AXI R channel
   input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rlast,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready,
   // status
   output logic                      rd_resp_err,
   output logic                      rd_len_err,
   output logic                      rd_bound_err,
   output logic                      rd_timeout_err
);

   localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
   localparam logic [2:0]  ARSIZE     = 3'($clog2(BEAT_BYTES));
   localparam int          TMO_W      = $clog2(TIMEOUT_CYC + 1);
   // last idle count before the stall is declared a timeout
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      AR_REQ = 2'd1,
      R_DATA = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]                arlen_q, arlen_d;
   logic                      arvalid_q, arvalid_d;
   logic [7:0]                beat_cnt_q, beat_cnt_d;
   logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
   logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                      rd_data_valid_q, rd_data_valid_d;
   logic                      rd_data_last_q, rd_data_last_d;
   logic                      resp_err_q, resp_err_d;
   logic                      len_err_q, len_err_d;
   logic                      bound_err_q, bound_err_d;
   logic                      timeout_err_q, timeout_err_d;

   logic [15:0]               burst_bytes;
   logic [15:0]               burst_end;
   logic                      bound_cross;
   logic                      unused_rid;

   // RID is not checked: only one transaction is ever outstanding
   assign unused_rid = ^m_axi_rid;

   // byte span of the requested burst relative to its 4 KB page (wide enough for 256 x 32 B)
   always_comb begin
      burst_bytes = ({8'd0, rd_burst_len} + 16'd1) * 16'(BEAT_BYTES);
      burst_end   = {4'd0, rd_addr[11:0]} + burst_bytes;
      bound_cross = (burst_end > 16'd4096);
   end

   // next-state and datapath updates for the IDLE -> AR_REQ -> R_DATA sequence
   always_comb begin
      state_d         = state_q;
      araddr_d        = araddr_q;
      arlen_d         = arlen_q;
      arvalid_d       = arvalid_q;
      beat_cnt_d      = beat_cnt_q;
      tmo_cnt_d       = tmo_cnt_q;
      rd_data_d       = rd_data_q;
      rd_data_valid_d = 1'b0;
      rd_data_last_d  = 1'b0;
      resp_err_d      = 1'b0;
      len_err_d       = 1'b0;
      bound_err_d     = 1'b0;
      timeout_err_d   = timeout_err_q;

      case (state_q)
         IDLE: begin
            if (rd_req_en) begin
               araddr_d    = rd_addr;
               arlen_d     = rd_burst_len;
               beat_cnt_d  = 8'd0;
               arvalid_d   = 1'b1;
               bound_err_d = bound_cross;
               state_d     = AR_REQ;
            end
         end
         AR_REQ: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               tmo_cnt_d = '0;
               state_d   = R_DATA;
            end
         end
         R_DATA: begin
            if (m_axi_rvalid) begin
               rd_data_valid_d = 1'b1;
               rd_data_d       = m_axi_rdata;
               rd_data_last_d  = m_axi_rlast;
               resp_err_d      = (m_axi_rresp != 2'b00);
               // short burst: RLAST early; long burst: index reached ARLEN without RLAST
               len_err_d       = m_axi_rlast ? (beat_cnt_q != arlen_q)
                                             : (beat_cnt_q >= arlen_q);
               beat_cnt_d      = beat_cnt_q + 8'd1;
               tmo_cnt_d       = '0;
               if (m_axi_rlast) begin
                  state_d = IDLE;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               // counter parks here; the flag stays set and the FSM keeps waiting
               timeout_err_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            arvalid_d = 1'b0;
         end
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         araddr_q        <= '0;
         arlen_q         <= 8'd0;
         arvalid_q       <= 1'b0;
         beat_cnt_q      <= 8'd0;
         tmo_cnt_q       <= '0;
         rd_data_q       <= '0;
         rd_data_valid_q <= 1'b0;
         rd_data_last_q  <= 1'b0;
         resp_err_q      <= 1'b0;
         len_err_q       <= 1'b0;
         bound_err_q     <= 1'b0;
         timeout_err_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         araddr_q        <= araddr_d;
         arlen_q         <= arlen_d;
         arvalid_q       <= arvalid_d;
         beat_cnt_q      <= beat_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_last_q  <= rd_data_last_d;
         resp_err_q      <= resp_err_d;
         len_err_q       <= len_err_d;
         bound_err_q     <= bound_err_d;
         timeout_err_q   <= timeout_err_d;
      end
   end

   assign rd_req_ack     = (state_q == IDLE) && rd_req_en;

   assign m_axi_arid     = '0;
   assign m_axi_araddr   = araddr_q;
   assign m_axi_arlen    = arlen_q;
   assign m_axi_arsize   = ARSIZE;
   assign m_axi_arburst  = 2'b01;
   assign m_axi_arlock   = 1'b0;
   assign m_axi_arcache  = 4'b0011;
   assign m_axi_arprot   = 3'b000;
   assign m_axi_arqos    = 4'b0000;
   assign m_axi_arvalid  = arvalid_q;
   assign m_axi_rready   = (state_q == R_DATA);

   assign rd_data_valid  = rd_data_valid_q;
   assign rd_data        = rd_data_q;
   assign rd_data_last   = rd_data_last_q;
   assign rd_resp_err    = resp_err_q;
   assign rd_len_err     = len_err_q;
   assign rd_bound_err   = bound_err_q;
   assign rd_timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_master
// Brief    : Self-checking bench for axi_rd_master. A randomizing AXI slave
//            and command driver feed the DUT; a transaction-level model
//            predicts every output each cycle, and directed scenarios pin
//            the model with hand-computed counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_master;

   localparam int DW  = 128;
   localparam int AW  = 32;
   localparam int IDW = 4;
   localparam int TMO = 1024;
   localparam int BB  = DW / 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            rd_req_en = 1'b0;
   logic            rd_req_ack;
   logic [AW-1:0]   rd_addr = '0;
   logic [7:0]      rd_burst_len = 8'd0;
   logic            rd_data_valid;
   logic [DW-1:0]   rd_data;
   logic            rd_data_last;
   logic [IDW-1:0]  m_axi_arid;
   logic [AW-1:0]   m_axi_araddr;
   logic [7:0]      m_axi_arlen;
   logic [2:0]      m_axi_arsize;
   logic [1:0]      m_axi_arburst;
   logic            m_axi_arlock;
   logic [3:0]      m_axi_arcache;
   logic [2:0]      m_axi_arprot;
   logic [3:0]      m_axi_arqos;
   logic            m_axi_arvalid;
   logic            m_axi_arready = 1'b0;
   logic [IDW-1:0]  m_axi_rid = '0;
   logic [DW-1:0]   m_axi_rdata = '0;
   logic [1:0]      m_axi_rresp = 2'b00;
   logic            m_axi_rlast = 1'b0;
   logic            m_axi_rvalid = 1'b0;
   logic            m_axi_rready;
   logic            rd_resp_err;
   logic            rd_len_err;
   logic            rd_bound_err;
   logic            rd_timeout_err;

   always #5 clk = ~clk;

   axi_rd_master #(
      .AXI_DATA_WIDTH(DW),
      .AXI_ADDR_WIDTH(AW),
      .AXI_ID_WIDTH  (IDW),
      .TIMEOUT_CYC   (TMO)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .rd_req_en     (rd_req_en),
      .rd_req_ack    (rd_req_ack),
      .rd_addr       (rd_addr),
      .rd_burst_len  (rd_burst_len),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rd_data_last  (rd_data_last),
      .m_axi_arid    (m_axi_arid),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arqos   (m_axi_arqos),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rid     (m_axi_rid),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .rd_resp_err   (rd_resp_err),
      .rd_len_err    (rd_len_err),
      .rd_bound_err  (rd_bound_err),
      .rd_timeout_err(rd_timeout_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- slave knobs ----------------
   int ar_lo      = 0;
   int ar_hi      = 0;
   int gap_pct    = 0;
   bit gap_alt    = 1'b0;
   bit r_block    = 1'b0;
   int force_last = -1;
   int bad_resp   = -1;

   // AXI slave: answers AR with a programmable delay, returns R beats with gaps
   initial begin : slave
      bit in_burst;
      bit alt;
      bit give;
      int beat;
      int blen;
      int ar_wait;
      int ar_target;
      in_burst = 1'b0; alt = 1'b0; beat = 0; blen = 0; ar_wait = 0; ar_target = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_burst = 1'b0;
            ar_wait  = 0;
         end else begin
            if (m_axi_rvalid && m_axi_rready) begin
               beat++;
               if (m_axi_rlast) begin
                  in_burst   = 1'b0;
                  force_last = -1;
                  bad_resp   = -1;
               end
            end
            if (m_axi_arvalid && m_axi_arready) begin
               in_burst = 1'b1;
               beat     = 0;
               blen     = int'(m_axi_arlen);
               ar_wait  = 0;
               alt      = 1'b0;
            end else if (m_axi_arvalid) begin
               ar_wait++;
            end
         end
         @(posedge clk);
         #1;
         if (m_axi_arvalid && ar_wait == 0) ar_target = $urandom_range(ar_hi, ar_lo);
         m_axi_arready = reset_n && m_axi_arvalid && (ar_wait >= ar_target);
         give = 1'b0;
         if (in_burst && reset_n && !r_block) begin
            if (gap_alt) begin
               give = alt;
               alt  = !alt;
            end else begin
               give = ($urandom_range(99, 0) >= gap_pct);
            end
         end
         m_axi_rvalid = give;
         m_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
         m_axi_rid    = IDW'($urandom);
         if (give) begin
            m_axi_rlast = (beat == ((force_last >= 0) ? force_last : blen));
            m_axi_rresp = (beat == bad_resp) ? 2'b10 : 2'b00;
         end else begin
            m_axi_rlast = 1'($urandom);
            m_axi_rresp = 2'($urandom);
         end
      end
   end

   // ---------------- transaction-level model ----------------
   bit            m_busy, m_ar_done, m_tmo;
   bit            p_beat, p_last, p_resp, p_len, p_bound;
   logic [AW-1:0] m_addr;
   logic [7:0]    m_len;
   int            m_idx, m_idle;
   logic [DW-1:0] m_hold;

   int cyc, n_ack, n_ar, n_dv, n_last, last_at, n_resp, n_len, n_bound, n_rl, rl1_cyc, ack_cyc;

   task automatic clr_cnt();
      n_ack = 0; n_ar = 0; n_dv = 0; n_last = 0; last_at = 0;
      n_resp = 0; n_len = 0; n_bound = 0; n_rl = 0; rl1_cyc = -1; ack_cyc = -1;
   endtask

   // compares every output each cycle, then advances the model on this cycle's inputs
   initial begin : model
      int unsigned span_end;
      m_busy = 0; m_ar_done = 0; m_tmo = 0; m_hold = '0; m_addr = '0; m_len = 8'd0;
      m_idx = 0; m_idle = 0; cyc = 0;
      p_beat = 0; p_last = 0; p_resp = 0; p_len = 0; p_bound = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            m_busy = 0; m_ar_done = 0; m_tmo = 0; m_hold = '0; m_idx = 0; m_idle = 0;
            p_beat = 0; p_last = 0; p_resp = 0; p_len = 0; p_bound = 0;
            chk("rst_araddr", m_axi_araddr, '0);
            chk("rst_arlen", m_axi_arlen, '0);
         end
         chk("ack", rd_req_ack, !m_busy && rd_req_en);
         chk("arvalid", m_axi_arvalid, m_busy && !m_ar_done);
         if (m_busy && !m_ar_done) begin
            chk("araddr", m_axi_araddr, m_addr);
            chk("arlen", m_axi_arlen, m_len);
         end
         chk("rready", m_axi_rready, m_busy && m_ar_done);
         chk("dvalid", rd_data_valid, p_beat);
         chk("dlast", rd_data_last, p_last);
         chk("rdata", rd_data, m_hold);
         chk("resp_err", rd_resp_err, p_resp);
         chk("len_err", rd_len_err, p_len);
         chk("bound_err", rd_bound_err, p_bound);
         chk("timeout_err", rd_timeout_err, m_tmo);
         chk("ar_const", {m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                          m_axi_arcache, m_axi_arprot, m_axi_arqos},
             {4'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});

         if (reset_n) begin
            if (rd_req_ack) begin n_ack++; ack_cyc = cyc; end
            if (m_axi_arvalid && m_axi_arready) n_ar++;
            if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
               n_rl++;
               if (n_rl == 1) rl1_cyc = cyc;
            end
            if (rd_data_valid) n_dv++;
            if (rd_data_last) begin n_last++; last_at = n_dv; end
            if (rd_resp_err) n_resp++;
            if (rd_len_err) n_len++;
            if (rd_bound_err) n_bound++;

            p_beat = 0; p_last = 0; p_resp = 0; p_len = 0; p_bound = 0;
            if (!m_busy) begin
               if (rd_req_en) begin
                  m_busy    = 1;
                  m_ar_done = 0;
                  m_addr    = rd_addr;
                  m_len     = rd_burst_len;
                  m_idx     = 0;
                  span_end  = int'(rd_addr[11:0]) + (int'(rd_burst_len) + 1) * BB;
                  p_bound   = (span_end > 4096);
               end
            end else if (!m_ar_done) begin
               if (m_axi_arready) begin
                  m_ar_done = 1;
                  m_idle    = 0;
               end
            end else if (m_axi_rvalid) begin
               p_beat = 1;
               p_last = m_axi_rlast;
               m_hold = m_axi_rdata;
               p_resp = (m_axi_rresp != 2'b00);
               p_len  = m_axi_rlast ? (m_idx != int'(m_len)) : (m_idx >= int'(m_len));
               m_idx++;
               m_idle = 0;
               if (m_axi_rlast) m_busy = 0;
            end else begin
               m_idle++;
               if (m_idle == TMO) m_tmo = 1;
            end
         end
      end
   end

   // ---------------- command driver ----------------
   task automatic issue(input logic [AW-1:0] a, input logic [7:0] l, input bit keep);
      int w;
      bit got;
      w = 0;
      got = 1'b0;
      rd_req_en    = 1'b1;
      rd_addr      = a;
      rd_burst_len = l;
      while (!got && w < 4000) begin
         @(negedge clk);
         got = rd_req_ack;
         w++;
         @(posedge clk);
         #1;
      end
      chk("ack_wait", got, 1'b1);
      if (!keep) rd_req_en = 1'b0;
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while ((m_busy || rd_data_valid) && w < 4000) begin
         @(negedge clk);
         w++;
      end
      chk("idle_wait", (w < 4000), 1'b1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin : main
      clr_cnt();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dvalid", rd_data_valid, 1'b0);
      chk("rst_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_rready", m_axi_rready, 1'b0);
      chk("rst_rdata", rd_data, '0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // single 16-beat burst, arready after 3 cycles
      clr_cnt(); ar_lo = 3; ar_hi = 3; gap_pct = 0;
      issue(32'h0000_1000, 8'd15, 1'b0);
      wait_idle();
      chk("t1_acks", n_ack, 1);
      chk("t1_ar_hs", n_ar, 1);
      chk("t1_beats", n_dv, 16);
      chk("t1_lasts", n_last, 1);
      chk("t1_last_pos", last_at, 16);
      chk("t1_errs", n_resp + n_len + n_bound, 0);

      // rvalid every other cycle
      clr_cnt(); ar_lo = 0; ar_hi = 1; gap_alt = 1'b1;
      issue(32'h0000_2000, 8'd7, 1'b0);
      wait_idle();
      gap_alt = 1'b0;
      chk("t2_beats", n_dv, 8);
      chk("t2_lasts", n_last, 1);

      // back-to-back commands with rd_req_en held high
      clr_cnt(); ar_lo = 0; ar_hi = 2;
      issue(32'h0000_3000, 8'd3, 1'b1);
      issue(32'h0000_3100, 8'd5, 1'b0);
      wait_idle();
      chk("t3_ar_hs", n_ar, 2);
      chk("t3_acks", n_ack, 2);
      chk("t3_ack_after_rlast", ack_cyc, rl1_cyc + 1);
      chk("t3_beats", n_dv, 10);

      // early RLAST and an error response
      clr_cnt(); force_last = 3; bad_resp = 1;
      issue(32'h0000_4000, 8'd7, 1'b0);
      wait_idle();
      chk("t4_len_err", n_len, 1);
      chk("t4_resp_err", n_resp, 1);
      chk("t4_beats", n_dv, 4);
      chk("t4_idle_rready", m_axi_rready, 1'b0);

      // 4 KB crossing and the exact-fit boundary
      clr_cnt();
      issue(32'h0000_0FC0, 8'd7, 1'b0);
      wait_idle();
      chk("t5_bound_cross", n_bound, 1);
      clr_cnt();
      issue(32'h0000_0F80, 8'd7, 1'b0);
      wait_idle();
      chk("t5_bound_fit", n_bound, 0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         bit keep;
         ar_lo   = 0;
         ar_hi   = $urandom_range(4, 0);
         gap_pct = $urandom_range(60, 0);
         keep    = (i != 39) && ($urandom_range(1, 0) == 1);
         issue($urandom, 8'($urandom_range(31, 0)), keep);
         if (!keep) begin
            repeat ($urandom_range(2, 0)) begin
               @(posedge clk);
               #1;
            end
         end
      end
      wait_idle();
      gap_pct = 0;

      // R channel stall -> sticky timeout, then reset mid-burst
      clr_cnt(); ar_lo = 0; ar_hi = 0; r_block = 1'b1;
      issue(32'h0000_5000, 8'd3, 1'b0);
      repeat (TMO + 8) @(posedge clk);
      #1;
      chk("t7_timeout_set", rd_timeout_err, 1'b1);
      chk("t7_still_waiting", m_axi_rready, 1'b1);
      chk("t7_no_beats", n_dv, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("t7_rst_timeout", rd_timeout_err, 1'b0);
      chk("t7_rst_rready", m_axi_rready, 1'b0);
      chk("t7_rst_arvalid", m_axi_arvalid, 1'b0);
      chk("t7_rst_dvalid", rd_data_valid, 1'b0);
      chk("t7_rst_rdata", rd_data, '0);
      chk("t7_rst_errs", {rd_resp_err, rd_len_err, rd_bound_err, rd_data_last}, 4'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      r_block = 1'b0;
      clr_cnt();
      issue(32'h0000_6000, 8'd1, 1'b0);
      wait_idle();
      chk("t7_recover_beats", n_dv, 2);
      chk("t7_recover_timeout", rd_timeout_err, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
